// File: rtl/jtframe_prog_pack.sv
// jtframe_prog_pack
// Packs the byte stream coming from the I/O controller into 16-bit SDRAM
// write requests. Each byte is queued in a 4-entry FIFO, mapped to one of
// four SDRAM banks by its byte address, and written to the lane selected by
// the address LSB. The byte is duplicated on both data lanes.
//
// Ports
//   clk_rom      : clock, everything on the rising edge
//   rst          : synchronous active-high reset
//   downloading  : ROM transfer in progress
//   ioctl_addr   : byte address of the incoming byte (25 bits)
//   ioctl_dout   : incoming byte
//   ioctl_wr     : one-cycle byte strobe
//   prog_addr    : SDRAM word address inside the selected bank
//   prog_data    : write data, {byte, byte}
//   prog_mask    : active-low byte-lane mask
//   prog_ba      : target bank
//   prog_we      : write request, held until prog_ack
//   prog_ack     : controller accepted the request
//   prog_rdy     : controller completed the write
//   dwnld_busy   : transfer not yet fully committed to SDRAM
//   ovf          : sticky, a byte was dropped because the FIFO was full
//
// Build option
//   JTFRAME_PROG_SWAB_EN : when defined, even addresses go to the upper lane
//                          (mask 2'b01) and odd addresses to the lower lane.
module jtframe_prog_pack #(
   parameter int          SDRAMW    = 23,
   parameter logic [24:0] BA1_START = 25'h040_0000,
   parameter logic [24:0] BA2_START = 25'h080_0000,
   parameter logic [24:0] BA3_START = 25'h0C0_0000
)(
   input  logic              clk_rom,
   input  logic              rst,
   input  logic              downloading,
   input  logic [24:0]       ioctl_addr,
   input  logic [7:0]        ioctl_dout,
   input  logic              ioctl_wr,
   output logic [SDRAMW-1:0] prog_addr,
   output logic [15:0]       prog_data,
   output logic [1:0]        prog_mask,
   output logic [1:0]        prog_ba,
   output logic              prog_we,
   input  logic              prog_ack,
   input  logic              prog_rdy,
   output logic              dwnld_busy,
   output logic              ovf
);

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      WAIT_ACK = 2'd1,
      WAIT_RDY = 2'd2
   } state_t;

   state_t      state;
   logic [32:0] fifo_mem [0:3];
   logic [1:0]  wr_ptr;
   logic [1:0]  rd_ptr;
   logic [2:0]  count;
   logic        dl_last;

   logic        push_req;
   logic        full;
   logic        push;
   logic        pop;
   logic [24:0] head_addr;
   logic [7:0]  head_byte;
   logic [1:0]  head_ba;
   logic [24:0] head_off;

   // Bank number for a byte address: highest bank whose start is not above it.
   function automatic logic [1:0] bank_of(input logic [24:0] addr);
      logic [1:0] ba;
      if (addr >= BA3_START)      ba = 2'd3;
      else if (addr >= BA2_START) ba = 2'd2;
      else if (addr >= BA1_START) ba = 2'd1;
      else                        ba = 2'd0;
      return ba;
   endfunction

   // First byte address of a bank.
   function automatic logic [24:0] bank_start(input logic [1:0] ba);
      logic [24:0] start;
      case (ba)
         2'd1:    start = BA1_START;
         2'd2:    start = BA2_START;
         2'd3:    start = BA3_START;
         default: start = 25'd0;
      endcase
      return start;
   endfunction

   // Active-low lane mask for the byte at an even or odd address.
   function automatic logic [1:0] lane_mask(input logic odd);
      logic [1:0] mask;
`ifdef JTFRAME_PROG_SWAB_EN
      mask = odd ? 2'b10 : 2'b01;
`else
      mask = odd ? 2'b01 : 2'b10;
`endif
      return mask;
   endfunction

   // FIFO status and head decode. A full FIFO drops the push even when the
   // same cycle pops, so "full" looks only at the current count.
   always_comb begin
      push_req  = ioctl_wr & downloading;
      full      = (count == 3'd4);
      push      = push_req & ~full;
      pop       = (state == IDLE) && (count != 3'd0);
      head_addr = fifo_mem[rd_ptr][32:8];
      head_byte = fifo_mem[rd_ptr][7:0];
      head_ba   = bank_of(head_addr);
      head_off  = head_addr - bank_start(head_ba);
   end

   // FIFO storage; stale entries after reset are harmless as pointers restart.
   always_ff @(posedge clk_rom) begin
      if (push && !rst) begin
         fifo_mem[wr_ptr] <= {ioctl_addr, ioctl_dout};
      end
   end

   // FIFO pointers and occupancy.
   always_ff @(posedge clk_rom) begin
      if (rst) begin
         wr_ptr <= 2'd0;
         rd_ptr <= 2'd0;
         count  <= 3'd0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 2'd1;
         if (pop)  rd_ptr <= rd_ptr + 2'd1;
         count <= count + {2'b00, push} - {2'b00, pop};
      end
   end

   // Status flags: overflow (sticky until next transfer start) and busy.
   always_ff @(posedge clk_rom) begin
      if (rst) begin
         dl_last    <= 1'b0;
         ovf        <= 1'b0;
         dwnld_busy <= 1'b0;
      end else begin
         dl_last <= downloading;
         // a drop on the very edge a new transfer starts still gets flagged
         if (push_req && full)            ovf <= 1'b1;
         else if (downloading && !dl_last) ovf <= 1'b0;
         if (downloading)                           dwnld_busy <= 1'b1;
         else if (count == 3'd0 && state == IDLE)   dwnld_busy <= 1'b0;
      end
   end

   // Request handshake with the SDRAM controller; outputs change only on pop.
   always_ff @(posedge clk_rom) begin
      if (rst) begin
         state     <= IDLE;
         prog_we   <= 1'b0;
         prog_addr <= {SDRAMW{1'b0}};
         prog_data <= 16'd0;
         prog_mask <= 2'b00;
         prog_ba   <= 2'd0;
      end else begin
         case (state)
            IDLE: begin
               if (pop) begin
                  prog_addr <= SDRAMW'(head_off >> 1);
                  prog_data <= {head_byte, head_byte};
                  prog_mask <= lane_mask(head_addr[0]);
                  prog_ba   <= head_ba;
                  prog_we   <= 1'b1;
                  state     <= WAIT_ACK;
               end
            end
            WAIT_ACK: begin
               if (prog_ack) begin
                  prog_we <= 1'b0;
                  state   <= prog_rdy ? IDLE : WAIT_RDY;
               end
            end
            WAIT_RDY: begin
               if (prog_rdy) state <= IDLE;
            end
            default: begin
               prog_we <= 1'b0;
               state   <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: doc/jtframe_prog_pack.md
JTFRAME_PROG_PACK -- requirements
Module: jtframe_prog_pack

Interface
REQ-001 SHALL have parameter SDRAMW, default 23: SDRAM word-address width.
REQ-002 SHALL have parameter BA1_START, default 25'h040_0000: first byte address mapped to bank 1.
REQ-003 SHALL have parameter BA2_START, default 25'h080_0000: first byte address mapped to bank 2.
REQ-004 SHALL have parameter BA3_START, default 25'h0C0_0000: first byte address mapped to bank 3.
REQ-005 SHALL have port clk_rom, input, 1: the only clock; all logic on rising edge.
REQ-006 SHALL have port rst, input, 1: reset, synchronous, active-high.
REQ-007 SHALL have port downloading, input, 1: ROM transfer from the I/O controller in progress.
REQ-008 SHALL have port ioctl_addr, input, 25: byte address of the incoming byte.
REQ-009 SHALL have port ioctl_dout, input, 8: incoming byte.
REQ-010 SHALL have port ioctl_wr, input, 1: one-cycle strobe, byte valid.
REQ-011 SHALL have port prog_addr, output, SDRAMW: SDRAM word address within the bank.
REQ-012 SHALL have port prog_data, output, 16: write data, byte duplicated on both lanes.
REQ-013 SHALL have port prog_mask, output, 2: active-low byte-lane write mask.
REQ-014 SHALL have port prog_ba, output, 2: target bank.
REQ-015 SHALL have port prog_we, output, 1: write request to the SDRAM controller.
REQ-016 SHALL have port prog_ack, input, 1: controller accepted the request.
REQ-017 SHALL have port prog_rdy, input, 1: controller finished the write.
REQ-018 SHALL have port dwnld_busy, output, 1: transfer not yet fully committed to SDRAM.
REQ-019 SHALL have port ovf, output, 1: sticky flag, a byte was dropped.

Function
REQ-020 SHALL push {ioctl_addr, ioctl_dout} into a 4-entry FIFO when ioctl_wr && downloading; ioctl_wr with downloading low SHALL be ignored.
REQ-021 SHALL drop the byte and set ovf on a push while the FIFO holds 4 entries; a simultaneous pop SHALL NOT make room for that push.
REQ-022 SHALL clear ovf on the rising edge of downloading.
REQ-023 SHALL select the bank as 3 if addr>=BA3_START, else 2 if >=BA2_START, else 1 if >=BA1_START, else 0.
REQ-024 SHALL compute prog_addr = (addr - bank start) >> 1, truncated to SDRAMW bits.
REQ-025 SHALL drive prog_data = {byte, byte} and prog_mask = 2'b10 for an even address or 2'b01 for an odd address.
REQ-026 SHALL use a 3-state machine: IDLE, WAIT_ACK, WAIT_RDY.
REQ-027 IDLE with FIFO non-empty: pop the head, register prog_addr/data/mask/ba, set prog_we, go to WAIT_ACK.
REQ-028 prog_we SHALL rise on the edge after the push edge when the FIFO was empty and the state was IDLE (latency 1 cycle).
REQ-029 WAIT_ACK: hold prog_we and all prog_* outputs stable until prog_ack; on prog_ack clear prog_we and go to WAIT_RDY.
REQ-030 If prog_ack and prog_rdy are high in the same cycle in WAIT_ACK, clear prog_we and go directly to IDLE.
REQ-031 WAIT_RDY: on prog_rdy go to IDLE; the next write SHALL issue no earlier than the following edge.
REQ-032 dwnld_busy SHALL set on the edge where downloading is first sampled high, and clear only when downloading is low, the FIFO is empty and the state is IDLE.
REQ-033 The FIFO SHALL keep draining after downloading falls.

Reset
REQ-034 rst high SHALL empty the FIFO, force IDLE and set prog_we, prog_addr, prog_data, prog_mask, prog_ba, dwnld_busy and ovf to 0 on the next edge, including mid-handshake.
REQ-035 While rst is high, pushes SHALL be ignored.

Configuration
REQ-036 With macro JTFRAME_PROG_SWAB_EN defined, lane selection SHALL be inverted: even address gives prog_mask 2'b01, odd address gives 2'b10.
REQ-037 Without JTFRAME_PROG_SWAB_EN, the mapping of REQ-025 SHALL apply.

Verification
REQ-038 Write addr 0x000004, byte 0xA5, IDLE; ack after 3 cycles, rdy 2 cycles later -> prog_we high 1 cycle after push; prog_addr 2, data 0xA5A5, mask 2'b10, ba 0; prog_we held until ack.
REQ-039 Write addr 0x0C0_0003 -> ba 3, prog_addr 1, mask 2'b01; with JTFRAME_PROG_SWAB_EN defined -> mask 2'b10.
REQ-040 Burst of 6 writes on consecutive cycles, prog_ack held low -> 5 bytes kept (1 in flight, 4 queued), 6th dropped, ovf=1; the next downloading rise clears ovf.
REQ-041 downloading falls with 3 entries queued -> dwnld_busy stays 1 until the third prog_rdy returns to IDLE, then 0.
REQ-042 rst asserted in WAIT_ACK with 2 entries queued -> next edge: prog_we=0, FIFO empty, dwnld_busy=0, ovf=0; no further writes issued.
REQ-043 prog_ack and prog_rdy asserted in the same cycle -> IDLE next edge; a queued byte issues one edge later.
